// File: rtl/slot_free_list_allocator.sv
`default_nettype none
// ============================================================================
// Module      : slot_free_list_allocator
// Description : Owns a VECTOR_LENGTH-entry busy vector for a shared resource.
//               Grants the highest-numbered free slot one cycle after an
//               accepted request, accepts slot releases and a global flush.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk_in           - clock, all state on rising edge
//   reset_in         - asynchronous active-high reset
//   alloc_request_in - request one slot this cycle
//   alloc_ready_out  - at least one slot free (from registered state only)
//   alloc_valid_out  - one-cycle pulse after an accepted request
//   alloc_index_out  - granted slot, valid with alloc_valid_out
//   free_valid_in    - release slot free_index_in this cycle
//   free_index_in    - slot to release (out-of-range values ignored)
//   flush_in         - synchronous release of all slots, drops a grant
//   busy_vector_out  - bit i set while slot i is allocated
//   busy_count_out   - population count of busy_vector_out
//   full_out         - all slots allocated
//   empty_out        - no slot allocated
//   error_out        - (only with SLOT_ALLOCATOR_ERROR_CHECK_EN) sticky flag
//                      for double free, out-of-range free, request while full
//
// Optional feature macro: SLOT_ALLOCATOR_ERROR_CHECK_EN
// ============================================================================
module slot_free_list_allocator #(
    parameter int VECTOR_LENGTH = 8,
    parameter int INDEX_WIDTH   = 3
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     alloc_request_in,
    output logic                     alloc_ready_out,
    output logic                     alloc_valid_out,
    output logic [INDEX_WIDTH-1:0]   alloc_index_out,
    input  logic                     free_valid_in,
    input  logic [INDEX_WIDTH-1:0]   free_index_in,
    input  logic                     flush_in,
    output logic [VECTOR_LENGTH-1:0] busy_vector_out,
    output logic [INDEX_WIDTH:0]     busy_count_out,
    output logic                     full_out,
`ifdef SLOT_ALLOCATOR_ERROR_CHECK_EN
    output logic                     empty_out,
    output logic                     error_out
`else
    output logic                     empty_out
`endif
);

    localparam logic [0:0]         c_IDLE     = 1'b0;
    localparam logic [0:0]         c_GRANT    = 1'b1;
    localparam logic [INDEX_WIDTH:0] c_VL_COUNT = (INDEX_WIDTH + 1)'(VECTOR_LENGTH);

    logic [0:0]               r_state;
    logic [0:0]               w_state_next;
    logic [VECTOR_LENGTH-1:0] r_busy;
    logic [INDEX_WIDTH:0]     r_count;
    logic                     r_full;
    logic                     r_empty;
    logic [INDEX_WIDTH-1:0]   r_index;

    logic [INDEX_WIDTH-1:0]   w_sel;
    logic                     w_accept;
    logic                     w_free_in_range;
    logic [VECTOR_LENGTH-1:0] w_busy_next;
    logic [INDEX_WIDTH:0]     w_count_next;

    // Find-first-one from the top on the inverted busy vector. Ascending scan
    // where the last hit wins gives the highest free index. Returns 0 when
    // nothing is free; that case is excluded by r_full, not by the index.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            if (!r_busy[i]) begin
                w_sel = INDEX_WIDTH'(i);
            end
        end
    end

    // Readiness comes only from registered fullness, so a same-cycle free
    // cannot make a full allocator accept.
    assign w_accept        = alloc_request_in & ~r_full;
    assign w_free_in_range = ({1'b0, free_index_in} < c_VL_COUNT);

    // Clear before set: the selected slot is always free in the registered
    // vector, so a free of that same (already free) slot must not cancel it.
    always_comb begin
        w_busy_next = r_busy;
        if (free_valid_in && w_free_in_range) begin
            w_busy_next[free_index_in] = 1'b0;
        end
        if (w_accept) begin
            w_busy_next[w_sel] = 1'b1;
        end
        if (flush_in) begin
            w_busy_next = '0;
        end
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            w_count_next = w_count_next + (INDEX_WIDTH + 1)'(w_busy_next[i]);
        end
    end

    // Busy bookkeeping: vector, count and flags share one edge so they
    // always agree.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_busy  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_index <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_VL_COUNT);
            r_empty <= (w_count_next == '0);
            if (w_accept && !flush_in) begin
                r_index <= w_sel;
            end
        end
    end

    // Grant FSM: state register
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant FSM: next state. A flush drops a request accepted in its cycle.
    always_comb begin
        w_state_next = c_IDLE;
        if (w_accept && !flush_in) begin
            w_state_next = c_GRANT;
        end
    end

    // Grant FSM: outputs
    always_comb begin
        alloc_valid_out = (r_state == c_GRANT);
    end

    assign alloc_ready_out = ~r_full;
    assign alloc_index_out = r_index;
    assign busy_vector_out = r_busy;
    assign busy_count_out  = r_count;
    assign full_out        = r_full;
    assign empty_out       = r_empty;

`ifdef SLOT_ALLOCATOR_ERROR_CHECK_EN
    logic r_error;
    logic w_error_event;

    always_comb begin
        w_error_event = alloc_request_in & r_full;
        if (free_valid_in) begin
            if (!w_free_in_range) begin
                w_error_event = 1'b1;
            end else if (!r_busy[free_index_in]) begin
                w_error_event = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_error <= 1'b0;
        end else if (flush_in) begin
            r_error <= 1'b0;
        end else if (w_error_event) begin
            r_error <= 1'b1;
        end
    end

    assign error_out = r_error;
`endif

endmodule
`default_nettype wire
